// File: rtl/mem_sram_ctrl.sv
// mem_sram_ctrl: stalls the pipeline while a 32-bit load/store is split
// into two 16-bit SRAM accesses, each phase lasting WAIT_CYCLES clocks.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   MEM_R_EN/MEM_W_EN load/store request (read wins if both are set)
//   ALU_result        byte address; ST_val store data
//   ready             0 = freeze pipeline, 1 = done or no access
//   mem_read_data     last loaded word
//   SRAM_ADDR         halfword address; SRAM_DQ_out/SRAM_DQ_oe write bus
//   SRAM_DQ_in        read bus; SRAM_WE_N write strobe (active-low)
module mem_sram_ctrl #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] ALU_result,
    input  logic [31:0] ST_val,
    output logic        ready,
    output logic [31:0] mem_read_data,
    output logic [17:0] SRAM_ADDR,
    output logic [15:0] SRAM_DQ_out,
    output logic        SRAM_DQ_oe,
    input  logic [15:0] SRAM_DQ_in,
    output logic        SRAM_WE_N
);

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        WR_LO,
        WR_HI,
        DONE
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  wait_cnt;
    logic        phase_last;
    logic        in_access;
    logic [16:0] word;
    logic [17:0] addr_lo;
    logic [17:0] addr_hi;
    logic        unused_addr_bits;

    // The data region starts at byte 1024 (word 256). Its low two bits are
    // zero, so subtracting on the word-index slice is exact and already
    // truncated to the 17-bit SRAM word space.
    assign word    = ALU_result[18:2] - 17'd256;
    assign addr_lo = {word, 1'b0};
    assign addr_hi = {word, 1'b1};

    assign unused_addr_bits = ^{ALU_result[31:19], ALU_result[1:0]};

    assign phase_last = (wait_cnt == LAST_CNT);

    assign in_access = (state == RD_LO) || (state == RD_HI) ||
                       (state == WR_LO) || (state == WR_HI);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counter restarts on every state change so each phase is timed
    // from its own first cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 4'd0;
        end else if (state_nxt != state) begin
            wait_cnt <= 4'd0;
        end else if (in_access) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    // Sample the SRAM on the last cycle of each read phase, when the
    // address has been stable for the full access time.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_read_data <= 32'd0;
        end else if (phase_last && (state == RD_LO)) begin
            mem_read_data[15:0] <= SRAM_DQ_in;
        end else if (phase_last && (state == RD_HI)) begin
            mem_read_data[31:16] <= SRAM_DQ_in;
        end
    end

    always_comb begin
        state_nxt   = state;
        ready       = 1'b0;
        SRAM_ADDR   = 18'd0;
        SRAM_DQ_out = 16'd0;
        SRAM_DQ_oe  = 1'b0;
        SRAM_WE_N   = 1'b1;

        unique case (state)
            IDLE: begin
                ready = !MEM_R_EN && !MEM_W_EN;
                if (MEM_R_EN) begin
                    state_nxt = RD_LO;
                end else if (MEM_W_EN) begin
                    state_nxt = WR_LO;
                end
            end
            RD_LO: begin
                SRAM_ADDR = addr_lo;
                if (phase_last) begin
                    state_nxt = RD_HI;
                end
            end
            RD_HI: begin
                SRAM_ADDR = addr_hi;
                if (phase_last) begin
                    state_nxt = DONE;
                end
            end
            // Strobe released on the final cycle so address and data are
            // held past the rising edge of WE_N.
            WR_LO: begin
                SRAM_ADDR   = addr_lo;
                SRAM_DQ_out = ST_val[15:0];
                SRAM_DQ_oe  = 1'b1;
                SRAM_WE_N   = phase_last;
                if (phase_last) begin
                    state_nxt = WR_HI;
                end
            end
            WR_HI: begin
                SRAM_ADDR   = addr_hi;
                SRAM_DQ_out = ST_val[31:16];
                SRAM_DQ_oe  = 1'b1;
                SRAM_WE_N   = phase_last;
                if (phase_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                ready     = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
